// File: rtl/spi_burst_capture_buffer.sv
// Burst-read capture engine: stores spi_master burst words into a dual-port capture RAM window.
// Optional idle timeout is compiled in with `define SPI_CAPTURE_TIMEOUT_EN.
module spi_burst_capture_buffer #(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int COUNT_WIDTH    = 16,
  parameter int WINDOW         = 256,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_start,
  input  logic                   i_abort,
  input  logic [COUNT_WIDTH-1:0] i_burst_count,
  input  logic [ADDR_WIDTH-1:0]  i_base_addr,
  input  logic                   i_circular,
  input  logic                   i_burst_data_valid,
  input  logic [DATA_WIDTH-1:0]  i_spi_output_data,
  output logic                   o_busy,
  output logic                   o_outbuf_we,
  output logic [ADDR_WIDTH-1:0]  o_outbuf_addr,
  output logic [DATA_WIDTH-1:0]  o_outbuf_dat,
  output logic [COUNT_WIDTH-1:0] o_words_captured,
  output logic                   o_overflow,
  output logic                   o_timeout,
  output logic                   o_done
);

  // Offset must be able to hold WINDOW itself: that value marks a full linear window.
  localparam int OFF_WIDTH = $clog2(WINDOW + 1);
  localparam logic [OFF_WIDTH-1:0] LAST_OFF = OFF_WIDTH'(WINDOW - 1);
  localparam logic [OFF_WIDTH-1:0] FULL_OFF = OFF_WIDTH'(WINDOW);

  if (WINDOW < 1 || WINDOW > (2 ** ADDR_WIDTH) || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("spi_burst_capture_buffer: WINDOW or TIMEOUT_CYCLES out of range");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_DONE
  } state_t;

  state_t                 state;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic                   circular_q;
  logic [OFF_WIDTH-1:0]   offset;
  logic [COUNT_WIDTH-1:0] words_inc;
  logic                   window_full;

  assign words_inc   = o_words_captured + COUNT_WIDTH'(1);
  assign window_full = (offset == FULL_OFF);

`ifdef SPI_CAPTURE_TIMEOUT_EN
  localparam int TMR_WIDTH = $clog2(TIMEOUT_CYCLES + 1);
  // Firing one count early puts o_done exactly TIMEOUT_CYCLES cycles after the last strobe.
  localparam logic [TMR_WIDTH-1:0] TMR_LAST =
    (TIMEOUT_CYCLES > 1) ? TMR_WIDTH'(TIMEOUT_CYCLES - 2) : '0;
  logic [TMR_WIDTH-1:0] idle_cnt;
`else
  assign o_timeout = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state            <= ST_IDLE;
      count_q          <= '0;
      base_q           <= '0;
      circular_q       <= 1'b0;
      offset           <= '0;
      o_busy           <= 1'b0;
      o_outbuf_we      <= 1'b0;
      o_outbuf_addr    <= '0;
      o_outbuf_dat     <= '0;
      o_words_captured <= '0;
      o_overflow       <= 1'b0;
      o_done           <= 1'b0;
`ifdef SPI_CAPTURE_TIMEOUT_EN
      o_timeout        <= 1'b0;
      idle_cnt         <= '0;
`endif
    end else begin
      // NOTE: pulse outputs default low every cycle, so each accepted strobe yields exactly one write cycle.
      o_outbuf_we <= 1'b0;
      o_done      <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (i_start) begin
            count_q          <= i_burst_count;
            base_q           <= i_base_addr;
            circular_q       <= i_circular;
            offset           <= '0;
            o_words_captured <= '0;
            o_overflow       <= 1'b0;
`ifdef SPI_CAPTURE_TIMEOUT_EN
            o_timeout        <= 1'b0;
            idle_cnt         <= '0;
`endif
            if (i_burst_count == '0) begin
              state  <= ST_DONE;
              o_done <= 1'b1;
            end else begin
              state  <= ST_CAPTURE;
              o_busy <= 1'b1;
            end
          end
        end

        ST_CAPTURE: begin
          if (i_abort) begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end else if (i_burst_data_valid) begin
            o_words_captured <= words_inc;
`ifdef SPI_CAPTURE_TIMEOUT_EN
            idle_cnt         <= '0;
`endif
            // A full linear window drops the word but still counts it toward completion.
            if (circular_q || !window_full) begin
              o_outbuf_we   <= 1'b1;
              o_outbuf_addr <= base_q + ADDR_WIDTH'(offset);
              o_outbuf_dat  <= i_spi_output_data;
              offset        <= (circular_q && offset == LAST_OFF) ? '0 : offset + OFF_WIDTH'(1);
            end else begin
              o_overflow <= 1'b1;
            end
            if (words_inc == count_q) begin
              state  <= ST_DONE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end
          end
`ifdef SPI_CAPTURE_TIMEOUT_EN
          else if (idle_cnt == TMR_LAST) begin
            state     <= ST_DONE;
            o_busy    <= 1'b0;
            o_done    <= 1'b1;
            o_timeout <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + TMR_WIDTH'(1);
          end
`endif
        end

        ST_DONE: state <= ST_IDLE;

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
